fpu_dispatcher: RTL
===================

FPU_DISPATCHER -- requirements
Module: fpu_dispatcher

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- C_FPU_LAT, 2: cycles from fpu_en_o to fpu_valid_i for ADD/SUB/MUL/I2F/F2I.
- C_FMA_LAT, 3: the same for FMADD/FMSUB/FNMADD/FNMSUB.
- C_TAG_W, 5: destination tag width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: reset, synchronous, active-low.
- req_valid_i, in, 1: core request valid.
- req_ready_o, out, 1: request accepted when high together with req_valid_i.
- req_op_i, in, C_CMD: FPU command.
- req_a_i, req_b_i, req_c_i, in, C_OP each: operands.
- req_rm_i, in, C_RM: rounding mode.
- req_prec_i, in, C_PC: divsqrt precision.
- req_tag_i, in, C_TAG_W: destination tag.
- fpu_en_o, out, 1: one-cycle issue strobe to the FPU.
- fpu_op_o, out, C_CMD: command to the FPU.
- operand_a_o, operand_b_o, operand_c_o, out, C_OP each: operands to the FPU.
- rm_o, out, C_RM: rounding mode to the FPU.
- prec_o, out, C_PC: precision to the FPU.
- fpu_result_i, in, C_OP: FPU result.
- fpu_valid_i, in, 1: FPU result valid.
- fpu_flags_i, in, C_FFLAG: FPU flags.
- divsqrt_busy_i, in, 1: divsqrt unit occupied.
- rsp_valid_o, out, 1: response strobe; no backpressure.
- rsp_result_o, out, C_OP: response result.
- rsp_flags_o, out, C_FFLAG: response flags.
- rsp_tag_o, out, C_TAG_W: tag of the answered request.
- idle_o, out, 1: nothing in flight.
- err_o, out, 1: sticky protocol error.

Function
REQ-003 Issue: a request accepted in cycle t SHALL drive fpu_en_o=1 in t+1 with all FPU-side outputs registered; fpu_en_o SHALL be 0 in every other cycle.
REQ-004 The FPU-side data outputs SHALL hold their last value when fpu_en_o=0.
REQ-005 Op classes: fixed-latency ops SHALL use C_FPU_LAT or C_FMA_LAT; DIV/SQRT SHALL be the divsqrt class.
REQ-006 Fixed-latency op: the FPU result SHALL be expected in cycle t+1+L_op.
REQ-007 The scoreboard SHALL reserve each result-return cycle together with its tag, as a shift register of depth max(C_FPU_LAT,C_FMA_LAT)+1.
REQ-008 req_ready_o SHALL be low for a fixed-latency op whose return cycle is already reserved; req_ready_o MAY depend combinationally on req_op_i.
REQ-009 The FSM SHALL have the states RUN, DRAIN and DIV; reset state RUN.
REQ-010 RUN: fixed-latency ops SHALL be accepted per REQ-008; a valid divsqrt request SHALL move the FSM to DRAIN without being accepted.
REQ-011 DRAIN: req_ready_o SHALL stay 0 until the scoreboard is empty and divsqrt_busy_i=0; the divsqrt request is then accepted, its tag stored, and the FSM moves to DIV.
REQ-012 DIV: req_ready_o SHALL be 0; the first fpu_valid_i SHALL answer with the stored tag, and the FSM SHALL return to RUN in the next cycle.
REQ-013 Response: rsp_valid_o SHALL assert in the cycle after the matching fpu_valid_i, carrying the registered result, flags and tag.
REQ-014 Responses SHALL be in completion order, which is not acceptance order (an FMA can be overtaken by a later ADD).
REQ-015 fpu_valid_i with no reservation (outside DIV) SHALL set err_o and produce no response.
REQ-016 A reservation reaching its cycle without fpu_valid_i SHALL set err_o and drop that tag.
REQ-017 An unsupported req_op_i SHALL be accepted, never issued, and SHALL set err_o.
REQ-018 A reservation being consumed and a new acceptance in the same cycle SHALL both take effect.
REQ-019 idle_o SHALL be 1 iff state is RUN, the scoreboard is empty, fpu_en_o=0 and rsp_valid_o=0.

Reset
REQ-020 With rst_ni low at a clk_i edge, all outputs SHALL be 0, the scoreboard cleared, the stored tag cleared, err_o cleared and the FSM in RUN.
REQ-021 Reset mid-operation SHALL discard in-flight work without responses; the FPU shares clk_i/rst_ni, so no stale fpu_valid_i follows.

Structure
REQ-022 C_OP, C_RM, C_CMD, C_PC, C_FFLAG and the C_FPU_*_CMD codes SHALL come from fpu_defs.
REQ-023 The op-class enum and the FSM state typedef SHALL be added to fpu_defs.
REQ-024 There SHALL be one sub-module, fpu_dispatch_sb: the reservation/tag shift register with a collision query.

Verification (C_FPU_LAT=2, C_FMA_LAT=3)
REQ-025 ADD tag 3 accepted at cycle 0 -> fpu_en_o at 1; fpu_valid_i at 3 -> rsp_valid_o at 4 with tag 3.
REQ-026 FMA accepted at 1 (returns 5), ADD offered at 2 -> req_ready_o=0 at 2; ADD accepted at 3; responses at 6 (FMA tag) and 7 (ADD tag).
REQ-027 ADD accepted at 0, DIV offered at 1 -> DRAIN; DIV accepted at 3 with divsqrt_busy_i=0; fpu_valid_i 10 cycles later -> rsp_valid_o with the DIV tag; no acceptance meanwhile.
REQ-028 Spurious fpu_valid_i in RUN with an empty scoreboard -> err_o=1, rsp_valid_o=0, err_o held until reset.
REQ-029 Three back-to-back MULs at 0, 1, 2 with rst_ni low at 3 -> no responses, idle_o=1 and all outputs 0 at cycle 4.
REQ-030 Operand b of 0x3F800000 with FNMSUB -> fpu_op_o=C_FPU_FNMSUB_CMD and operand_b_o=0x3F800000 in the fpu_en_o cycle.

Source files
------------

// File: rtl/fpu_defs.sv
// FPU interface definitions shared by the dispatcher and its scoreboard:
// operand/field widths, command encodings, op classes and dispatcher states.
package fpu_defs;

    localparam int C_OP    = 32;
    localparam int C_RM    = 3;
    localparam int C_CMD   = 4;
    localparam int C_PC    = 2;
    localparam int C_FFLAG = 5;

    localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'd0;
    localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'd1;
    localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'd2;
    localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'd3;
    localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'd4;
    localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'd5;
    localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'd6;
    localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'd7;
    localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'd8;
    localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'd9;
    localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'd10;

    // Latency class of a command: plain fixed latency, fused multiply-add
    // fixed latency, variable-latency divide/sqrt, or not supported.
    typedef enum logic [1:0] {
        OPC_FPU     = 2'd0,
        OPC_FMA     = 2'd1,
        OPC_DIVSQRT = 2'd2,
        OPC_ILLEGAL = 2'd3
    } op_class_e;

    // Dispatcher control states.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DIV   = 2'd2
    } disp_state_e;

    function automatic op_class_e op_class(input logic [C_CMD-1:0] op);
        op_class_e cls;
        case (op)
            C_FPU_ADD_CMD, C_FPU_SUB_CMD, C_FPU_MUL_CMD,
            C_FPU_I2F_CMD, C_FPU_F2I_CMD:                  cls = OPC_FPU;
            C_FPU_FMADD_CMD, C_FPU_FMSUB_CMD,
            C_FPU_FNMADD_CMD, C_FPU_FNMSUB_CMD:            cls = OPC_FMA;
            C_FPU_DIV_CMD, C_FPU_SQRT_CMD:                 cls = OPC_DIVSQRT;
            default:                                       cls = OPC_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fpu_dispatch_sb.sv
// Result-return scoreboard: one slot per future cycle. Slot 0 is the cycle
// currently being resolved; everything shifts one slot toward 0 each cycle.
// A push into slot L lands in slot 0 exactly L cycles after the push edge.
module fpu_dispatch_sb
    import fpu_defs::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int SLOT_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [SLOT_W-1:0] push_slot_i,
    input  logic [TAG_W-1:0]  push_tag_i,
    input  logic [SLOT_W-1:0] query_slot_i,
    output logic              collide_o,
    output logic              head_vld_o,
    output logic [TAG_W-1:0]  head_tag_o,
    output logic              pending_o,
    output logic              empty_o
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    // Shift every reservation one cycle closer and insert the new one
    always_comb begin
        vld_d = vld_q >> 1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            tag_d[i] = tag_q[i+1];
        end
        tag_d[DEPTH-1] = '0;
        if (push_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (SLOT_W'(i) == push_slot_i) begin
                    vld_d[i] = 1'b1;
                    tag_d[i] = push_tag_i;
                end
            end
        end
    end

    // A query slot beyond the last entry is always free (nothing lives there)
    always_comb begin
        collide_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SLOT_W'(i) == query_slot_i) begin
                collide_o = vld_q[i];
            end
        end
    end

    // Reservation storage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign head_vld_o = vld_q[0];
    assign head_tag_o = tag_q[0];
    assign pending_o  = |vld_q[DEPTH-1:1];
    assign empty_o    = ~|vld_q;

endmodule

// File: rtl/fpu_dispatcher.sv
// Issues core FPU requests to a shared FPU, tracks fixed-latency results in
// a return-cycle scoreboard, serialises divide/sqrt behind a drain, and
// returns tagged responses in completion order.
module fpu_dispatcher
    import fpu_defs::*;
#(
    parameter int C_FPU_LAT = 2,
    parameter int C_FMA_LAT = 3,
    parameter int C_TAG_W   = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [C_CMD-1:0]   req_op_i,
    input  logic [C_OP-1:0]    req_a_i,
    input  logic [C_OP-1:0]    req_b_i,
    input  logic [C_OP-1:0]    req_c_i,
    input  logic [C_RM-1:0]    req_rm_i,
    input  logic [C_PC-1:0]    req_prec_i,
    input  logic [C_TAG_W-1:0] req_tag_i,
    output logic               fpu_en_o,
    output logic [C_CMD-1:0]   fpu_op_o,
    output logic [C_OP-1:0]    operand_a_o,
    output logic [C_OP-1:0]    operand_b_o,
    output logic [C_OP-1:0]    operand_c_o,
    output logic [C_RM-1:0]    rm_o,
    output logic [C_PC-1:0]    prec_o,
    input  logic [C_OP-1:0]    fpu_result_i,
    input  logic               fpu_valid_i,
    input  logic [C_FFLAG-1:0] fpu_flags_i,
    input  logic               divsqrt_busy_i,
    output logic               rsp_valid_o,
    output logic [C_OP-1:0]    rsp_result_o,
    output logic [C_FFLAG-1:0] rsp_flags_o,
    output logic [C_TAG_W-1:0] rsp_tag_o,
    output logic               idle_o,
    output logic               err_o
);

    localparam int SB_DEPTH = ((C_FPU_LAT > C_FMA_LAT) ? C_FPU_LAT : C_FMA_LAT) + 1;
    localparam int SLOT_W   = $clog2(SB_DEPTH + 1);

    op_class_e          req_cls;
    logic [SLOT_W-1:0]  push_slot;
    logic [SLOT_W-1:0]  query_slot;
    logic               accept;
    logic               sb_push;
    logic               sb_collide;
    logic               sb_head_vld;
    logic [C_TAG_W-1:0] sb_head_tag;
    logic               sb_pending;
    logic               sb_empty;

    disp_state_e        state_q;
    logic [C_TAG_W-1:0] div_tag_q;
    logic               fpu_en_q;
    logic [C_CMD-1:0]   fpu_op_q;
    logic [C_OP-1:0]    op_a_q;
    logic [C_OP-1:0]    op_b_q;
    logic [C_OP-1:0]    op_c_q;
    logic [C_RM-1:0]    rm_q;
    logic [C_PC-1:0]    prec_q;
    logic               rsp_valid_q;
    logic [C_OP-1:0]    rsp_result_q;
    logic [C_FFLAG-1:0] rsp_flags_q;
    logic [C_TAG_W-1:0] rsp_tag_q;
    logic               err_q;

    // Classify the command and find the slot its result will occupy; the
    // collision check looks one slot further because the table shifts at
    // the same edge the reservation is written.
    always_comb begin
        req_cls    = op_class(req_op_i);
        push_slot  = (req_cls == OPC_FMA) ? SLOT_W'(C_FMA_LAT) : SLOT_W'(C_FPU_LAT);
        query_slot = push_slot + SLOT_W'(1);
    end

    // Acceptance per state; in DRAIN a reservation retiring this cycle
    // (slot 0) does not block the divide/sqrt.
    always_comb begin
        req_ready_o = 1'b0;
        case (state_q)
            ST_RUN:   req_ready_o = req_valid_i &&
                                    ((req_cls == OPC_ILLEGAL) ||
                                     (((req_cls == OPC_FPU) || (req_cls == OPC_FMA)) && !sb_collide));
            ST_DRAIN: req_ready_o = req_valid_i && (req_cls == OPC_DIVSQRT) &&
                                    !sb_pending && !divsqrt_busy_i;
            default:  req_ready_o = 1'b0;
        endcase
    end

    assign accept  = req_ready_o;
    assign sb_push = accept && ((req_cls == OPC_FPU) || (req_cls == OPC_FMA));

    fpu_dispatch_sb #(
        .DEPTH  (SB_DEPTH),
        .TAG_W  (C_TAG_W),
        .SLOT_W (SLOT_W)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (sb_push),
        .push_slot_i  (push_slot),
        .push_tag_i   (req_tag_i),
        .query_slot_i (query_slot),
        .collide_o    (sb_collide),
        .head_vld_o   (sb_head_vld),
        .head_tag_o   (sb_head_tag),
        .pending_o    (sb_pending),
        .empty_o      (sb_empty)
    );

    // Control FSM with registered issue, response and error outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_RUN;
            div_tag_q    <= '0;
            fpu_en_q     <= 1'b0;
            fpu_op_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_c_q       <= '0;
            rm_q         <= '0;
            prec_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            fpu_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;

            if (accept && (req_cls != OPC_ILLEGAL)) begin
                fpu_en_q <= 1'b1;
                fpu_op_q <= req_op_i;
                op_a_q   <= req_a_i;
                op_b_q   <= req_b_i;
                op_c_q   <= req_c_i;
                rm_q     <= req_rm_i;
                prec_q   <= req_prec_i;
            end
            if (accept && (req_cls == OPC_ILLEGAL)) begin
                err_q <= 1'b1;
            end

            // Fixed-latency completions: match against the reservation due now
            if (sb_head_vld) begin
                if (fpu_valid_i) begin
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= fpu_result_i;
                    rsp_flags_q  <= fpu_flags_i;
                    rsp_tag_q    <= sb_head_tag;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (fpu_valid_i && (state_q != ST_DIV)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ST_RUN: begin
                    if (req_valid_i && (req_cls == OPC_DIVSQRT)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        state_q   <= ST_DIV;
                        div_tag_q <= req_tag_i;
                    end else if (!(req_valid_i && (req_cls == OPC_DIVSQRT))) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DIV: begin
                    if (fpu_valid_i) begin
                        state_q      <= ST_RUN;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= fpu_result_i;
                        rsp_flags_q  <= fpu_flags_i;
                        rsp_tag_q    <= div_tag_q;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign fpu_en_o     = fpu_en_q;
    assign fpu_op_o     = fpu_op_q;
    assign operand_a_o  = op_a_q;
    assign operand_b_o  = op_b_q;
    assign operand_c_o  = op_c_q;
    assign rm_o         = rm_q;
    assign prec_o       = prec_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign err_o        = err_q;
    assign idle_o       = (state_q == ST_RUN) && sb_empty && !fpu_en_q && !rsp_valid_q;

endmodule
